mm_fifo_periph: RTL and testbench

MM_FIFO_PERIPH -- requirements
Module: mm_fifo_periph

---
 rtl/mm_fifo_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mm_fifo_periph.sv | 124 ++++++++++++
 tb/tb_mm_fifo_periph.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mm_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit layout and status word type for mm_fifo_periph.
package mm_fifo_pkg;

  localparam int unsigned RegData   = 0;
  localparam int unsigned RegStatus = 1;
  localparam int unsigned RegCtrl   = 2;

  localparam int unsigned StRxCountLsb = 0;
  localparam int unsigned StTxCountLsb = 5;
  localparam int unsigned StRxEmpty    = 10;
  localparam int unsigned StTxFull     = 11;
  localparam int unsigned StRxOvf      = 12;
  localparam int unsigned StTxOvf      = 13;
  localparam int unsigned StRxUdf      = 14;

  localparam int unsigned CtrlRxFlush  = 0;
  localparam int unsigned CtrlTxFlush  = 1;
  localparam int unsigned CtrlClrFlags = 2;

  typedef struct packed {
    logic       rsvd;
    logic       rx_udf;
    logic       tx_ovf;
    logic       rx_ovf;
    logic       tx_full;
    logic       rx_empty;
    logic [4:0] tx_count;
    logic [4:0] rx_count;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; pop-through-full and flush-over-push priority.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // A pop on a full FIFO frees the slot the push writes into.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PtrW'(1);
      if (do_pop)  rd_d = rd_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mm_fifo_periph.sv
// Memory-mapped RX/TX FIFO peripheral: DATA/STATUS/CTRL registers at BASE_ADDR.
// Optional sticky overflow/underflow flags are built when MM_FIFO_ERRFLAG_EN is defined.
module mm_fifo_periph
  import mm_fifo_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hC000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mm_we,
  input  logic              mm_re,
  output logic [DATA_W-1:0] rdata,
  input  logic              ext_push,
  input  logic [DATA_W-1:0] ext_din,
  output logic              ext_full,
  input  logic              ext_pop,
  output logic [DATA_W-1:0] ext_dout,
  output logic              ext_valid
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] AddrData   = BASE_ADDR + ADDR_W'(RegData);
  localparam logic [ADDR_W-1:0] AddrStatus = BASE_ADDR + ADDR_W'(RegStatus);
  localparam logic [ADDR_W-1:0] AddrCtrl   = BASE_ADDR + ADDR_W'(RegCtrl);

  logic hit_data, hit_status, hit_ctrl;
  logic rx_pop, tx_push, rx_flush, tx_flush;
  logic [DATA_W-1:0] rx_dout;
  logic [CntW-1:0]   rx_count, tx_count;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_ovf, tx_ovf, rx_udf;
  status_t status;

  assign hit_data   = (addr == AddrData);
  assign hit_status = (addr == AddrStatus);
  assign hit_ctrl   = (addr == AddrCtrl);

  assign rx_pop   = mm_re && hit_data;
  assign tx_push  = mm_we && hit_data;
  assign rx_flush = mm_we && hit_ctrl && wdata[CtrlRxFlush];
  assign tx_flush = mm_we && hit_ctrl && wdata[CtrlTxFlush];

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .push (ext_push),
    .pop  (rx_pop),
    .flush(rx_flush),
    .din  (ext_din),
    .dout (rx_dout),
    .count(rx_count),
    .full (rx_full),
    .empty(rx_empty)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .push (tx_push),
    .pop  (ext_pop),
    .flush(tx_flush),
    .din  (wdata),
    .dout (ext_dout),
    .count(tx_count),
    .full (tx_full),
    .empty(tx_empty)
  );

  assign ext_full  = rx_full;
  assign ext_valid = !tx_empty;

`ifdef MM_FIFO_ERRFLAG_EN
  logic rx_ovf_q, tx_ovf_q, rx_udf_q;
  logic clr_flags;

  assign clr_flags = mm_we && hit_ctrl && wdata[CtrlClrFlags];

  // A new event in the same cycle as a clear still leaves its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      rx_ovf_q <= (rx_ovf_q && !clr_flags) || (ext_push && rx_full && !rx_pop);
      tx_ovf_q <= (tx_ovf_q && !clr_flags) || (tx_push && tx_full && !ext_pop);
      rx_udf_q <= (rx_udf_q && !clr_flags) || (rx_pop && rx_empty);
    end
  end

  assign rx_ovf = rx_ovf_q;
  assign tx_ovf = tx_ovf_q;
  assign rx_udf = rx_udf_q;
`else
  assign rx_ovf = 1'b0;
  assign tx_ovf = 1'b0;
  assign rx_udf = 1'b0;
`endif

  always_comb begin
    status          = '0;
    status.rx_count = 5'(rx_count);
    status.tx_count = 5'(tx_count);
    status.rx_empty = rx_empty;
    status.tx_full  = tx_full;
    status.rx_ovf   = rx_ovf;
    status.tx_ovf   = tx_ovf;
    status.rx_udf   = rx_udf;
  end

  always_comb begin
    rdata = '0;
    if (mm_re) begin
      if (hit_data)        rdata = rx_dout;
      else if (hit_status) rdata = DATA_W'(status);
    end
  end

endmodule

// File: tb/tb_mm_fifo_periph.sv
// Directed self-checking bench for mm_fifo_periph (default parameters).
module tb_mm_fifo_periph;

  localparam logic [15:0] AData   = 16'hC000;
  localparam logic [15:0] AStatus = 16'hC001;
  localparam logic [15:0] ACtrl   = 16'hC002;
`ifdef MM_FIFO_ERRFLAG_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam logic [15:0] RxOvf = ErrEn ? 16'h1000 : 16'h0000;
  localparam logic [15:0] TxOvf = ErrEn ? 16'h2000 : 16'h0000;
  localparam logic [15:0] RxUdf = ErrEn ? 16'h4000 : 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wdata, rdata, ext_din, ext_dout;
  logic        mm_we, mm_re, ext_push, ext_full, ext_pop, ext_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mm_fifo_periph dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .mm_we    (mm_we),
    .mm_re    (mm_re),
    .rdata    (rdata),
    .ext_push (ext_push),
    .ext_din  (ext_din),
    .ext_full (ext_full),
    .ext_pop  (ext_pop),
    .ext_dout (ext_dout),
    .ext_valid(ext_valid)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads register, checks the combinational rdata, then lets the strobe take effect.
  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr  = a;
    mm_re = 1'b1;
    #1;
    check(tag, rdata, exp);
    tick();
    mm_re = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    mm_we = 1'b1;
    tick();
    mm_we = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    ext_din  = d;
    ext_push = 1'b1;
    tick();
    ext_push = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 16'h0; wdata = 16'h0; mm_we = 1'b0; mm_re = 1'b0;
    ext_push = 1'b0; ext_din = 16'h0; ext_pop = 1'b0;
    tick();
    tick();
    check("rst_ext_full", {15'h0, ext_full}, 16'h0);
    check("rst_ext_valid", {15'h0, ext_valid}, 16'h0);
    check("rst_ext_dout", ext_dout, 16'h0);
    check("rst_rdata", rdata, 16'h0);
    rst_n = 1'b1;
    tick();
    rd(AStatus, 16'h0400, "status_after_reset");
    rd(16'hC003, 16'h0000, "unmapped_read");

    // Basic RX ordering
    rx_push(16'h1111);
    rx_push(16'h2222);
    rx_push(16'h3333);
    rd(AStatus, 16'h0003, "status_rx3");
    rd(AData, 16'h1111, "rx_data0");
    rd(AData, 16'h2222, "rx_data1");
    rd(AData, 16'h3333, "rx_data2");
    rd(AStatus, 16'h0400, "status_rx_drained");

    // TX overfill: ninth word dropped
    for (int i = 0; i < 9; i++) wr(AData, 16'hA000 + 16'(i));
    rd(AStatus, 16'h0D00 | TxOvf, "status_tx_full");
    check("tx_valid_full", {15'h0, ext_valid}, 16'h1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_head%0d", i), ext_dout, 16'hA000 + 16'(i));
      ext_pop = 1'b1;
      tick();
      ext_pop = 1'b0;
    end
    check("tx_valid_drained", {15'h0, ext_valid}, 16'h0);
    check("tx_dout_drained", ext_dout, 16'h0);
    wr(ACtrl, 16'h0004);
    rd(AStatus, 16'h0400, "status_after_clr1");

    // RX full: dropped push, then push+pop in one cycle
    for (int i = 0; i < 8; i++) rx_push(16'hB000 + 16'(i));
    check("rx_ext_full", {15'h0, ext_full}, 16'h1);
    rx_push(16'hDEAD);
    ext_din  = 16'hC0DE;
    ext_push = 1'b1;
    rd(AData, 16'hB000, "rx_full_pushpop_head");
    ext_push = 1'b0;
    rd(AStatus, 16'h0008 | RxOvf, "status_rx_full_after_pushpop");
    check("rx_ext_full_kept", {15'h0, ext_full}, 16'h1);
    for (int i = 1; i < 8; i++) rd(AData, 16'hB000 + 16'(i), $sformatf("rx_full_data%0d", i));
    rd(AData, 16'hC0DE, "rx_tail_new_word");
    wr(ACtrl, 16'h0004);

    // Underflow on empty RX
    rd(AData, 16'h0000, "rx_empty_read");
    rd(AStatus, 16'h0400 | RxUdf, "status_rx_udf");
    wr(ACtrl, 16'h0004);
    rd(AStatus, 16'h0400, "status_udf_cleared");

    // Flush beats a same-cycle push
    rx_push(16'h5555);
    rx_push(16'h6666);
    ext_din  = 16'h7777;
    ext_push = 1'b1;
    wr(ACtrl, 16'h0001);
    ext_push = 1'b0;
    rd(AStatus, 16'h0400, "status_rx_flush");
    wr(AData, 16'h1234);
    wr(ACtrl, 16'h0002);
    check("tx_flush_valid", {15'h0, ext_valid}, 16'h0);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 4; i++) begin
      rx_push(16'hE000 + 16'(i));
      wr(AData, 16'hF000 + 16'(i));
    end
    check("pre_reset_valid", {15'h0, ext_valid}, 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {15'h0, ext_valid}, 16'h0);
    check("async_rst_dout", ext_dout, 16'h0);
    #3;
    rst_n = 1'b1;
    tick();
    rd(AStatus, 16'h0400, "status_after_midreset");
    rd(AData, 16'h0000, "rx_data_after_midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
